// File: rtl/reflet_arbiter_pkg.sv
// Shared encodings for the reflet two-master bus arbiter.
package reflet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/reflet_bus_arbiter_if.sv
// Master-side handshakes and peripheral bus of the reflet arbiter.
// Lock inputs exist only when REFLET_ARBITER_LOCK_EN is defined.
interface reflet_bus_arbiter_if #(
  parameter int wordsize = 8
);
  logic                m0_req;
  logic [wordsize-1:0] m0_addr;
  logic                m0_write_en;
  logic [wordsize-1:0] m0_data_out;
  logic                m0_ack;
  logic [wordsize-1:0] m0_data_in;

  logic                m1_req;
  logic [wordsize-1:0] m1_addr;
  logic                m1_write_en;
  logic [wordsize-1:0] m1_data_out;
  logic                m1_ack;
  logic [wordsize-1:0] m1_data_in;

`ifdef REFLET_ARBITER_LOCK_EN
  logic                m0_lock;
  logic                m1_lock;
`endif

  logic [wordsize-1:0] bus_addr;
  logic                bus_write_en;
  logic [wordsize-1:0] bus_data_out;
  logic [wordsize-1:0] bus_data_in;
  logic                busy;

  // slave: the arbiter itself; master: the requesting masters plus peripherals.
  modport slave (
    input  m0_req, m0_addr, m0_write_en, m0_data_out,
    output m0_ack, m0_data_in,
    input  m1_req, m1_addr, m1_write_en, m1_data_out,
    output m1_ack, m1_data_in,
`ifdef REFLET_ARBITER_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    output bus_addr, bus_write_en, bus_data_out,
    input  bus_data_in,
    output busy
  );

  modport master (
    output m0_req, m0_addr, m0_write_en, m0_data_out,
    input  m0_ack, m0_data_in,
    output m1_req, m1_addr, m1_write_en, m1_data_out,
    input  m1_ack, m1_data_in,
`ifdef REFLET_ARBITER_LOCK_EN
    output m0_lock, m1_lock,
`endif
    input  bus_addr, bus_write_en, bus_data_out,
    output bus_data_in,
    input  busy
  );

endinterface

// File: rtl/reflet_rr_pick2.sv
// Two-way round-robin pick: masked requests, tie goes to the master that was not last served.
module reflet_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic mask0,
  input  logic mask1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);
  logic elig0;
  logic elig1;

  assign elig0       = req0 & ~mask0;
  assign elig1       = req1 & ~mask1;
  assign grant_valid = elig0 | elig1;
  assign grant_idx   = (elig0 & elig1) ? ~last : elig1;

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin arbiter for the reflet system bus, one transaction at a time.
// Define REFLET_ARBITER_LOCK_EN to let a master chain up to max_lock locked transactions.
module reflet_bus_arbiter
  import reflet_arbiter_pkg::*;
#(
  parameter int wordsize     = 8,
  parameter int read_latency = 1,
  parameter int max_lock     = 4
) (
  input logic                 clk,
  input logic                 reset,
  reflet_bus_arbiter_if.slave arb
);
  localparam int              chain_w  = $clog2(max_lock + 1);
  localparam logic [chain_w-1:0] chain_max = chain_w'(max_lock);
  localparam logic [3:0]      lat_load = (read_latency > 0) ? 4'(read_latency - 1) : 4'd0;

  arb_state_t          state, state_next;
  logic                last;
  logic [1:0]          mask;
  logic                gidx;
  logic [wordsize-1:0] lat_addr;
  logic                lat_we;
  logic [wordsize-1:0] lat_wdata;
  logic [3:0]          cnt;
  logic [wordsize-1:0] din0, din1;
  logic [chain_w-1:0]  chain, chain_inc;

  logic                grant_valid, grant_idx;
  logic [wordsize-1:0] sel_addr, sel_wdata;
  logic                sel_we;
  logic                capture;
  logic                lock_g;
  logic                hold;

  logic                ack0, ack1;
  logic [wordsize-1:0] bus_addr_c, bus_dout_c;
  logic                bus_we_c;

  reflet_rr_pick2 u_pick (
    .req0        (arb.m0_req),
    .req1        (arb.m1_req),
    .mask0       (mask[0]),
    .mask1       (mask[1]),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef REFLET_ARBITER_LOCK_EN
  assign lock_g = (gidx == M1) ? arb.m1_lock : arb.m0_lock;
`else
  assign lock_g = 1'b0;
`endif

  assign sel_addr  = (grant_idx == M1) ? arb.m1_addr     : arb.m0_addr;
  assign sel_we    = (grant_idx == M1) ? arb.m1_write_en : arb.m0_write_en;
  assign sel_wdata = (grant_idx == M1) ? arb.m1_data_out : arb.m0_data_out;

  // Saturating so a master that keeps locking while alone cannot wrap the count.
  assign chain_inc = (chain < chain_max) ? chain + chain_w'(1) : chain;
  assign hold      = lock_g && (chain_inc < chain_max);

  assign capture = (state == ISSUE && !lat_we && read_latency == 0) ||
                   (state == WAIT && cnt == 4'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    bus_addr_c = '0;
    bus_dout_c = '0;
    bus_we_c   = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_next = ISSUE;
      ISSUE: begin
        bus_addr_c = lat_addr;
        bus_dout_c = lat_wdata;
        bus_we_c   = lat_we;
        state_next = (lat_we || read_latency == 0) ? DONE : WAIT;
      end
      WAIT: begin
        bus_addr_c = lat_addr;
        bus_dout_c = lat_wdata;
        if (cnt == 4'd0) state_next = DONE;
      end
      DONE: begin
        ack0       = (gidx == M0);
        ack1       = (gidx == M1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      last      <= M1;
      mask      <= '0;
      gidx      <= M0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      cnt       <= '0;
      din0      <= '0;
      din1      <= '0;
      chain     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          mask <= '0;
          if (grant_valid) begin
            gidx      <= grant_idx;
            last      <= grant_idx;
            lat_addr  <= sel_addr;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            if (grant_idx != gidx) chain <= '0;
          end
        end
        ISSUE: if (!lat_we) cnt <= lat_load;
        WAIT:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
        DONE: begin
          // A held lock keeps the master unmasked and makes the other one "last" so it wins a tie.
          if (hold) begin
            mask <= '0;
            last <= ~gidx;
          end else begin
            mask <= (gidx == M1) ? 2'b10 : 2'b01;
          end
          chain <= lock_g ? chain_inc : '0;
        end
        default: ;
      endcase
      if (capture && gidx == M0) din0 <= arb.bus_data_in;
      if (capture && gidx == M1) din1 <= arb.bus_data_in;
    end
  end

  assign arb.m0_ack       = ack0;
  assign arb.m1_ack       = ack1;
  assign arb.m0_data_in   = din0;
  assign arb.m1_data_in   = din1;
  assign arb.bus_addr     = bus_addr_c;
  assign arb.bus_write_en = bus_we_c;
  assign arb.bus_data_out = bus_dout_c;
  assign arb.busy         = (state != IDLE);

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter; peripheral model returns addr^8'h5A one cycle late.
module tb_reflet_bus_arbiter;
  localparam int RL = 1;

  logic clk;
  logic reset;
  logic [7:0] rd_pipe;
  int checks   = 0;
  int failures = 0;

  reflet_bus_arbiter_if #(.wordsize(8)) bif ();

  reflet_bus_arbiter #(
    .wordsize(8), .read_latency(RL), .max_lock(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_pipe <= bif.bus_addr ^ 8'h5A;
  assign bif.bus_data_in = rd_pipe;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_m(input int m, input bit req, input logic [7:0] addr,
                       input bit we, input logic [7:0] dout);
    if (m == 0) begin
      bif.m0_req = req; bif.m0_addr = addr; bif.m0_write_en = we; bif.m0_data_out = dout;
    end else begin
      bif.m1_req = req; bif.m1_addr = addr; bif.m1_write_en = we; bif.m1_data_out = dout;
    end
  endtask

  task automatic drive_req(input int m, input bit req);
    if (m == 0) bif.m0_req = req;
    else        bif.m1_req = req;
  endtask

  // Returns at a negedge with reset released: that negedge is cycle 0 of the next test.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    set_m(0, 1'b0, 8'h00, 1'b0, 8'h00);
    set_m(1, 1'b0, 8'h00, 1'b0, 8'h00);
`ifdef REFLET_ARBITER_LOCK_EN
    bif.m0_lock = 1'b0;
    bif.m1_lock = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
      checks++; if ({bif.m0_ack, bif.m1_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks: got %b expected 00", {bif.m0_ack, bif.m1_ack}); end
      checks++; if ({bif.m0_data_in, bif.m1_data_in} !== 16'h0000) begin failures++; $display("FAIL reset_data_in: got %h expected 0000", {bif.m0_data_in, bif.m1_data_in}); end
      checks++; if ({bif.bus_addr, bif.bus_write_en, bif.bus_data_out} !== 17'h0) begin failures++; $display("FAIL reset_bus: got %h expected 0", {bif.bus_addr, bif.bus_write_en, bif.bus_data_out}); end
    end
  endtask

  task automatic test_read();
    int we_cnt = 0;
    apply_reset();
    set_m(0, 1'b1, 8'h12, 1'b0, 8'h00);
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if (bif.bus_addr !== 8'h12) begin failures++; $display("FAIL read_bus_addr: got %h expected 12", bif.bus_addr); end
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL read_busy: got %b expected 1", bif.busy); end
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if (bif.m0_ack !== 1'b0) begin failures++; $display("FAIL read_early_ack: got %b expected 0", bif.m0_ack); end
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if (bif.m0_ack !== 1'b1) begin failures++; $display("FAIL read_ack: got %b expected 1", bif.m0_ack); end
    checks++; if (bif.m0_data_in !== 8'h48) begin failures++; $display("FAIL read_data: got %h expected 48", bif.m0_data_in); end
    drive_req(0, 1'b0);
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if (bif.m0_ack !== 1'b0) begin failures++; $display("FAIL read_ack_width: got %b expected 0", bif.m0_ack); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL read_we_count: got %0d expected 0", we_cnt); end
  endtask

  task automatic test_write();
    int we_cnt = 0;
    apply_reset();
    set_m(1, 1'b1, 8'h30, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (bif.m1_data_in !== 8'h6A) begin failures++; $display("FAIL write_pre_read: got %h expected 6A", bif.m1_data_in); end
    drive_req(1, 1'b0);
    repeat (2) @(negedge clk);
    set_m(1, 1'b1, 8'h81, 1'b1, 8'hAB);
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if ({bif.bus_write_en, bif.bus_addr, bif.bus_data_out} !== {1'b1, 8'h81, 8'hAB}) begin
      failures++; $display("FAIL write_bus: got we=%b addr=%h data=%h expected we=1 addr=81 data=AB", bif.bus_write_en, bif.bus_addr, bif.bus_data_out);
    end
    @(negedge clk);
    we_cnt += int'(bif.bus_write_en);
    checks++; if (bif.m1_ack !== 1'b1) begin failures++; $display("FAIL write_ack: got %b expected 1", bif.m1_ack); end
    checks++; if (bif.m1_data_in !== 8'h6A) begin failures++; $display("FAIL write_data_in: got %h expected 6A", bif.m1_data_in); end
    drive_req(1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      we_cnt += int'(bif.bus_write_en);
    end
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL write_we_count: got %0d expected 1", we_cnt); end
  endtask

  task automatic test_alternate();
    bit e0, e1;
    apply_reset();
    set_m(0, 1'b1, 8'h05, 1'b0, 8'h00);
    set_m(1, 1'b1, 8'h06, 1'b0, 8'h00);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      e0 = (c % 4 == 3) && ((c / 4) % 2 == 0);
      e1 = (c % 4 == 3) && ((c / 4) % 2 == 1);
      checks++; if ({bif.m1_ack, bif.m0_ack} !== {e1, e0}) begin
        failures++; $display("FAIL alt_acks c=%0d: got %b expected %b", c, {bif.m1_ack, bif.m0_ack}, {e1, e0});
      end
      if (e0) begin
        checks++; if (bif.m0_data_in !== 8'h5F) begin failures++; $display("FAIL alt_m0_data: got %h expected 5F", bif.m0_data_in); end
      end
      if (e1) begin
        checks++; if (bif.m1_data_in !== 8'h5C) begin failures++; $display("FAIL alt_m1_data: got %h expected 5C", bif.m1_data_in); end
      end
    end
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
  endtask

  task automatic test_mask();
    apply_reset();
    set_m(0, 1'b1, 8'h20, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (bif.m0_ack !== 1'b1) begin failures++; $display("FAIL mask_ack: got %b expected 1", bif.m0_ack); end
    @(negedge clk);
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mask_idle_busy: got %b expected 0", bif.busy); end
    @(negedge clk);
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mask_no_repeat: got busy=%b expected 0", bif.busy); end
    drive_req(0, 1'b0);
    @(negedge clk);
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mask_after_drop: got %b expected 0", bif.busy); end
  endtask

  task automatic test_reset_abort();
    int m1_acks = 0;
    apply_reset();
    set_m(1, 1'b1, 8'h33, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL abort_in_wait: got busy=%b expected 1", bif.busy); end
    reset = 1'b1;
    set_m(0, 1'b1, 8'h44, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    m1_acks += int'(bif.m1_ack);
    checks++; if ({bif.busy, bif.m0_ack, bif.bus_write_en} !== 3'b000) begin
      failures++; $display("FAIL abort_ctrl: got %b expected 000", {bif.busy, bif.m0_ack, bif.bus_write_en});
    end
    checks++; if ({bif.bus_addr, bif.bus_data_out, bif.m0_data_in, bif.m1_data_in} !== 32'h0) begin
      failures++; $display("FAIL abort_data: got %h expected 0", {bif.bus_addr, bif.bus_data_out, bif.m0_data_in, bif.m1_data_in});
    end
    @(negedge clk);
    m1_acks += int'(bif.m1_ack);
    checks++; if (bif.bus_addr !== 8'h44) begin failures++; $display("FAIL abort_m0_first: got addr %h expected 44", bif.bus_addr); end
    repeat (2) begin
      @(negedge clk);
      m1_acks += int'(bif.m1_ack);
    end
    checks++; if (bif.m0_ack !== 1'b1) begin failures++; $display("FAIL abort_m0_ack: got %b expected 1", bif.m0_ack); end
    checks++; if (m1_acks !== 0) begin failures++; $display("FAIL abort_no_m1_ack: got %0d expected 0", m1_acks); end
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
  endtask

`ifdef REFLET_ARBITER_LOCK_EN
  task automatic test_lock();
    int order[$];
    int exp_order[5] = '{0, 0, 0, 0, 1};
    apply_reset();
    set_m(0, 1'b1, 8'h05, 1'b0, 8'h00);
    set_m(1, 1'b1, 8'h06, 1'b0, 8'h00);
    bif.m0_lock = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (bif.m0_ack === 1'b1) order.push_back(0);
      if (bif.m1_ack === 1'b1) order.push_back(1);
    end
    checks++; if (order.size() < 5) begin
      failures++; $display("FAIL lock_ack_count: got %0d expected at least 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (order[i] != exp_order[i]) begin
          failures++; $display("FAIL lock_order[%0d]: got m%0d expected m%0d", i, order[i], exp_order[i]);
        end
      end
    end
    bif.m0_lock = 1'b0;
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
  endtask
`endif

  // Transaction-timeline reference: a grant at IDLE cycle gc acks at gc+2 (write) or gc+2+RL (read).
  task automatic test_random();
    bit have = 1'b0;
    int gc = 0, ac = 0;
    bit g = 1'b0, g_we = 1'b0, last = 1'b1;
    logic [7:0] g_addr = '0, g_dout = '0;
    logic [7:0] exp_din [2];
    bit pend [2];
    bit late [2];
    logic [1:0] ack_obs, req_now, msk, elig;
    bit e_busy, e_ack0, e_ack1, e_we, in_bus;
    logic [7:0] e_addr;
    apply_reset();
    for (int m = 0; m < 2; m++) begin
      exp_din[m] = '0; pend[m] = 1'b0; late[m] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_bus = have && cyc > gc && cyc < ac;
      e_busy = have && cyc > gc && cyc <= ac;
      e_ack0 = have && cyc == ac && g == 1'b0;
      e_ack1 = have && cyc == ac && g == 1'b1;
      e_addr = in_bus ? g_addr : 8'h00;
      e_we   = have && cyc == gc + 1 && g_we;
      if (have && cyc == ac && !g_we) exp_din[g] = g_addr ^ 8'h5A;
      checks++; if (bif.busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d: got %b expected %b", cyc, bif.busy, e_busy); end
      checks++; if ({bif.m1_ack, bif.m0_ack} !== {e_ack1, e_ack0}) begin
        failures++; $display("FAIL rnd_acks cyc=%0d: got %b expected %b", cyc, {bif.m1_ack, bif.m0_ack}, {e_ack1, e_ack0});
      end
      checks++; if (bif.bus_addr !== e_addr) begin failures++; $display("FAIL rnd_bus_addr cyc=%0d: got %h expected %h", cyc, bif.bus_addr, e_addr); end
      checks++; if (bif.bus_write_en !== e_we) begin failures++; $display("FAIL rnd_bus_we cyc=%0d: got %b expected %b", cyc, bif.bus_write_en, e_we); end
      if (!in_bus || cyc == gc + 1) begin
        checks++; if (bif.bus_data_out !== (in_bus ? g_dout : 8'h00)) begin
          failures++; $display("FAIL rnd_bus_dout cyc=%0d: got %h expected %h", cyc, bif.bus_data_out, in_bus ? g_dout : 8'h00);
        end
      end
      checks++; if (bif.m0_data_in !== exp_din[0]) begin failures++; $display("FAIL rnd_m0_data cyc=%0d: got %h expected %h", cyc, bif.m0_data_in, exp_din[0]); end
      checks++; if (bif.m1_data_in !== exp_din[1]) begin failures++; $display("FAIL rnd_m1_data cyc=%0d: got %h expected %h", cyc, bif.m1_data_in, exp_din[1]); end

      ack_obs = {bif.m1_ack, bif.m0_ack};
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && ack_obs[m]) begin
          pend[m] = 1'b0;
          late[m] = ($urandom_range(0, 2) == 0);
          if (!late[m]) drive_req(m, 1'b0);
        end else if (late[m]) begin
          late[m] = 1'b0;
          drive_req(m, 1'b0);
        end else if (!pend[m] && $urandom_range(0, 1) == 1) begin
          pend[m] = 1'b1;
          set_m(m, 1'b1, 8'($urandom), 1'($urandom), 8'($urandom));
        end
      end

      req_now = {bif.m1_req, bif.m0_req};
      if (!have || cyc > ac) begin
        msk  = (have && cyc == ac + 1) ? (g ? 2'b10 : 2'b01) : 2'b00;
        elig = req_now & ~msk;
        if (elig != 2'b00) begin
          g      = (elig == 2'b11) ? ~last : elig[1];
          last   = g;
          have   = 1'b1;
          gc     = cyc;
          g_addr = g ? bif.m1_addr : bif.m0_addr;
          g_we   = g ? bif.m1_write_en : bif.m0_write_en;
          g_dout = g ? bif.m1_data_out : bif.m0_data_out;
          ac     = cyc + (g_we ? 2 : 2 + RL);
        end
      end
    end
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_m(0, 1'b0, 8'h00, 1'b0, 8'h00);
    set_m(1, 1'b0, 8'h00, 1'b0, 8'h00);
`ifdef REFLET_ARBITER_LOCK_EN
    bif.m0_lock = 1'b0;
    bif.m1_lock = 1'b0;
`endif
    test_reset();
    test_read();
    test_write();
    test_alternate();
    test_mask();
    test_reset_abort();
`ifdef REFLET_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
